// File: rtl/train_state_timer.sv
// train_state_timer: millisecond countdown for the train controller.
// A change of present_state loads the countdown with the duration t.
// A 1 ms prescaler then decrements the count. When the count reaches
// zero the block raises a one-cycle timeout pulse and a sticky expired level.
module train_state_timer #(
  parameter int TICKS_PER_MS = 50000,
  parameter int PRESC_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  present_state,
  input  logic [18:0] t,
  input  logic        hold,
  output logic        busy,
  output logic        timeout,
  output logic        expired,
  output logic [18:0] remaining_ms
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUNNING = 2'd1;
  localparam logic [1:0] S_EXPIRED = 2'd2;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_MS - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         prev_q;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [18:0]        rem_q, rem_d;
  logic               timeout_q, timeout_d;
  logic               chg;

  // A state change is seen on the same edge that present_state first differs.
  assign chg = (present_state != prev_q);

  // Next-state logic. A state change overrides everything, including hold
  // and a simultaneous expiry.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    rem_d     = rem_q;
    timeout_d = 1'b0;
    if (chg) begin
      presc_d = '0;
      if (t != 19'd0) begin
        rem_d   = t;
        state_d = S_RUNNING;
      end else begin
        rem_d   = 19'd0;
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_RUNNING: begin
          if (!hold) begin
            if (presc_q == PRESC_MAX) begin
              presc_d = '0;
              if (rem_q != 19'd0) begin
                rem_d = rem_q - 19'd1;
              end
              if (rem_q <= 19'd1) begin
                state_d   = S_EXPIRED;
                timeout_d = 1'b1;
              end
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        S_EXPIRED: begin
          rem_d = 19'd0;
        end
        S_IDLE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Register all state. Reset takes effect immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      prev_q    <= 4'b0000;
      presc_q   <= '0;
      rem_q     <= 19'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= present_state;
      presc_q   <= presc_d;
      rem_q     <= rem_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy         = (state_q == S_RUNNING);
  assign expired      = (state_q == S_EXPIRED);
  assign timeout      = timeout_q;
  assign remaining_ms = rem_q;

endmodule

// File: tb/tb_train_state_timer.sv
// Directed testbench for train_state_timer, run with 4 clocks per millisecond.
module tb_train_state_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  present_state;
  logic [18:0] t;
  logic        hold;
  logic        busy, timeout, expired;
  logic [18:0] remaining_ms;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int e0;
  int sb[$];

  train_state_timer #(.TICKS_PER_MS(4), .PRESC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .present_state(present_state), .t(t),
    .hold(hold), .busy(busy), .timeout(timeout), .expired(expired),
    .remaining_ms(remaining_ms)
  );

  always #5 clk = ~clk;

  // Count rising edges of the clock.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then compare timeout against the cycle
  // at the front of the scoreboard queue.
  task automatic tick();
    logic exp;
    @(negedge clk);
    exp = 1'b0;
    if (sb.size() > 0 && sb[0] == cyc) begin
      exp = 1'b1;
      void'(sb.pop_front());
    end
    total++;
    assert (timeout === exp) else begin
      bad++;
      $error("FAIL timeout cyc=%0d observed=%b expected=%b", cyc, timeout, exp);
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Drive a new state at a falling edge. The next rising edge is the load edge.
  task automatic load(input logic [3:0] ps, input logic [18:0] dur);
    present_state = ps;
    t             = dur;
    e0            = cyc + 1;
    sb.delete();
    if (dur != 19'd0) sb.push_back(e0 + int'(dur) * 4);
  endtask

  initial begin
    rst_n = 1'b0; present_state = 4'd0; t = 19'd0; hold = 1'b0;
    tick();
    chk("rst_busy", {18'd0, busy}, 19'd0);
    chk("rst_exp", {18'd0, expired}, 19'd0);
    chk("rst_rem", remaining_ms, 19'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_busy", {18'd0, busy}, 19'd0);

    // Basic timed state. A later change of t alone is ignored.
    load(4'b0011, 19'd2000);
    tick();
    chk("t1_busy", {18'd0, busy}, 19'd1);
    chk("t1_rem", remaining_ms, 19'd2000);
    t = 19'd5;
    run_to(e0 + 4);
    chk("t1_rem4", remaining_ms, 19'd1999);
    run_to(e0 + 7999);
    chk("t1_rem_last", remaining_ms, 19'd1);
    run_to(e0 + 8000);
    chk("t1_expired", {18'd0, expired}, 19'd1);
    chk("t1_busy0", {18'd0, busy}, 19'd0);
    chk("t1_rem0", remaining_ms, 19'd0);
    tick();
    chk("t1_expired_hold", {18'd0, expired}, 19'd1);

    // Reload while running aborts the first count.
    load(4'b0100, 19'd1000);
    tick();
    chk("t2_exp_clr", {18'd0, expired}, 19'd0);
    chk("t2_rem", remaining_ms, 19'd1000);
    run_to(e0 + 2000);
    load(4'b0101, 19'd2000);
    tick();
    chk("t2_reload", remaining_ms, 19'd2000);
    run_to(e0 + 8000);
    chk("t2_expired", {18'd0, expired}, 19'd1);

    // Switching to an untimed state returns to IDLE without a timeout.
    load(4'b0011, 19'd2000);
    run_to(e0 + 100);
    load(4'b0000, 19'd0);
    tick();
    chk("t3_busy", {18'd0, busy}, 19'd0);
    chk("t3_rem", remaining_ms, 19'd0);
    chk("t3_exp", {18'd0, expired}, 19'd0);
    run_to(cyc + 9000);

    // Hold freezes the count for 100 cycles.
    load(4'b0011, 19'd2000);
    sb.delete();
    sb.push_back(e0 + 8100);
    run_to(e0 + 2000);
    chk("t4_rem_pre", remaining_ms, 19'd1500);
    hold = 1'b1;
    run_to(e0 + 2100);
    chk("t4_rem_held", remaining_ms, 19'd1500);
    hold = 1'b0;
    run_to(e0 + 2104);
    chk("t4_rem_post", remaining_ms, 19'd1499);
    run_to(e0 + 8099);
    chk("t4_not_yet", {18'd0, expired}, 19'd0);
    run_to(e0 + 8100);
    chk("t4_expired", {18'd0, expired}, 19'd1);

    // Asynchronous reset in the middle of a count.
    load(4'b0101, 19'd2000);
    run_to(e0 + 1000);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("t5_busy", {18'd0, busy}, 19'd0);
    chk("t5_rem", remaining_ms, 19'd0);
    chk("t5_exp", {18'd0, expired}, 19'd0);
    chk("t5_to", {18'd0, timeout}, 19'd0);
    present_state = 4'b0011; t = 19'd2000;
    tick(); tick();
    rst_n = 1'b1;
    load(4'b0011, 19'd2000);
    tick();
    chk("t5_reload", remaining_ms, 19'd2000);
    chk("t5_busy1", {18'd0, busy}, 19'd1);
    run_to(e0 + 8000);
    chk("t5_expired", {18'd0, expired}, 19'd1);

    // State change on the edge where the count would reach 0.
    load(4'b0110, 19'd1);
    sb.delete();
    run_to(e0 + 3);
    chk("t6_rem1", remaining_ms, 19'd1);
    load(4'b0111, 19'd3);
    tick();
    chk("t6_exp", {18'd0, expired}, 19'd0);
    chk("t6_rem", remaining_ms, 19'd3);
    chk("t6_busy", {18'd0, busy}, 19'd1);
    run_to(e0 + 12);
    chk("t6_expired", {18'd0, expired}, 19'd1);
    tick(); tick();
    chk("sb_empty", 19'(sb.size()), 19'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
